rr_arbiter: RTL and testbench

Round-robin arbiter that shares one downstream resource, such as a priority-encoder datapath or a bus port, between up to WIDTH requesters. It picks the next requester with the same lowest-set-bit isolation (x & -x) used by the team's encoder blocks, over a request vector masked by a rotating pointer. Ownership holds until the owner drops its request. Grants are registered and one-hot.

---
 rtl/rr_arbiter.sv | 139 +++++++++++++
 tb/tb_rr_arbiter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one registered one-hot grant among WIDTH requesters; optional hold timeout via RR_ARBITER_TIMEOUT_EN.
// Latency: request sampled in IDLE is granted after the same edge; one bubble cycle between owners.
// Backpressure: level requests only; ownership holds until the owner drops its request (or times out).
module rr_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic                     clk_i,
    input  logic                     srst_i,
    input  logic [WIDTH-1:0]         req_i,
    output logic [WIDTH-1:0]         grant_o,
    output logic                     grant_val_o,
    output logic [$clog2(WIDTH)-1:0] grant_idx_o,
    output logic                     timeout_o
);
    localparam int IDX_W = $clog2(WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic               timeout_q, timeout_d;

    logic [WIDTH-1:0]   mask;
    logic [WIDTH-1:0]   masked_req;
    logic [WIDTH-1:0]   pick_src;
    logic [WIDTH-1:0]   win_oh;
    logic [IDX_W-1:0]   win_idx;

`ifdef RR_ARBITER_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_HOLD + 1);
    logic [CNT_W-1:0]   cnt_q, cnt_d;
`endif

    // Pointer mask keeps only requesters strictly after the previous owner.
    always_comb begin
        mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            mask[i] = (i > int'(last_q));
        end
    end

    assign masked_req = req_i & mask;
    assign pick_src   = (|masked_req) ? masked_req : req_i;
    assign win_oh     = pick_src & (~pick_src + {{(WIDTH-1){1'b0}}, 1'b1});

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (win_oh[i]) begin
                win_idx = i[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        idx_d     = idx_q;
        last_d    = last_q;
        timeout_d = 1'b0;
`ifdef RR_ARBITER_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    grant_d = win_oh;
                    idx_d   = win_idx;
                    last_d  = win_idx;
                    state_d = GRANT;
`ifdef RR_ARBITER_TIMEOUT_EN
                    cnt_d   = CNT_W'(1);
`endif
                end
            end
            GRANT: begin
                // Release wins over a coincident timeout.
                if (!req_i[idx_q]) begin
                    grant_d = '0;
                    idx_d   = '0;
                    state_d = IDLE;
                end
`ifdef RR_ARBITER_TIMEOUT_EN
                else if (cnt_q == CNT_W'(MAX_HOLD)) begin
                    grant_d   = '0;
                    idx_d     = '0;
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            default: begin
                grant_d = '0;
                idx_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            idx_q     <= '0;
            last_q    <= IDX_W'(WIDTH - 1);
            timeout_q <= 1'b0;
`ifdef RR_ARBITER_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            timeout_q <= timeout_d;
`ifdef RR_ARBITER_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign grant_o     = grant_q;
    assign grant_val_o = |grant_q;
    assign grant_idx_o = idx_q;
`ifdef RR_ARBITER_TIMEOUT_EN
    assign timeout_o   = timeout_q;
`else
    assign timeout_o   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed vector bench for rr_arbiter with WIDTH=4, MAX_HOLD=4.
module tb_rr_arbiter;
    logic       clk_i = 1'b0;
    logic       srst_i = 1'b1;
    logic [3:0] req_i = 4'b0000;
    logic [3:0] grant_o;
    logic       grant_val_o;
    logic [1:0] grant_idx_o;
    logic       timeout_o;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] grant;
        logic [1:0] idx;
    } vec_t;

    vec_t vecs[$];

    rr_arbiter #(.WIDTH(4), .MAX_HOLD(4)) dut (
        .clk_i       (clk_i),
        .srst_i      (srst_i),
        .req_i       (req_i),
        .grant_o     (grant_o),
        .grant_val_o (grant_val_o),
        .grant_idx_o (grant_idx_o),
        .timeout_o   (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic add(input logic rst, input logic [3:0] req, input logic [3:0] g, input logic [1:0] i);
        vec_t v;
        v.rst = rst; v.req = req; v.grant = g; v.idx = i;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] eg, input logic [1:0] ei, input logic eto);
        check({tag, " grant"},   {4'b0, grant_o},     {4'b0, eg});
        check({tag, " val"},     {7'b0, grant_val_o}, {7'b0, (eg != 4'b0)});
        check({tag, " idx"},     {6'b0, grant_idx_o}, {6'b0, ei});
        check({tag, " timeout"}, {7'b0, timeout_o},   {7'b0, eto});
    endtask

    // Apply inputs, let one rising edge pass, settle before sampling.
    task automatic step(input logic rst, input logic [3:0] req);
        srst_i = rst;
        req_i  = req;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // Reset with all requests pending
        add(1, 4'b1111, 4'b0000, 2'd0);
        add(1, 4'b1111, 4'b0000, 2'd0);
        add(0, 4'b1111, 4'b0001, 2'd0);
        // Rotation over 1011, each owner drops for one cycle
        add(0, 4'b1011, 4'b0001, 2'd0);
        add(0, 4'b1010, 4'b0000, 2'd0);
        add(0, 4'b1011, 4'b0010, 2'd1);
        add(0, 4'b1011, 4'b0010, 2'd1);
        add(0, 4'b1001, 4'b0000, 2'd0);
        add(0, 4'b1011, 4'b1000, 2'd3);
        add(0, 4'b1011, 4'b1000, 2'd3);
        add(0, 4'b0011, 4'b0000, 2'd0);
        add(0, 4'b1011, 4'b0001, 2'd0);
        // Wrap-around after owner 3
        add(0, 4'b0000, 4'b0000, 2'd0);
        add(0, 4'b1000, 4'b1000, 2'd3);
        add(0, 4'b0000, 4'b0000, 2'd0);
        add(0, 4'b0101, 4'b0001, 2'd0);
        add(0, 4'b0101, 4'b0001, 2'd0);
        add(0, 4'b0100, 4'b0000, 2'd0);
        add(0, 4'b0100, 4'b0100, 2'd2);
        // Release bubble: owner 1 drops while 3 waits
        add(0, 4'b0000, 4'b0000, 2'd0);
        add(0, 4'b0010, 4'b0010, 2'd1);
        add(0, 4'b1010, 4'b0010, 2'd1);
        add(0, 4'b1000, 4'b0000, 2'd0);
        add(0, 4'b1000, 4'b1000, 2'd3);
        add(0, 4'b0000, 4'b0000, 2'd0);
        // Reset mid-grant, pointer returns to favour bit 0
        add(0, 4'b0100, 4'b0100, 2'd2);
        add(1, 4'b0110, 4'b0000, 2'd0);
        add(0, 4'b0110, 4'b0010, 2'd1);
        add(0, 4'b0000, 4'b0000, 2'd0);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].req);
            check_all($sformatf("v%0d", i), vecs[i].grant, vecs[i].idx, 1'b0);
        end

        // Constant 0011: timeout rotation when enabled, indefinite hold otherwise
        for (int k = 1; k <= 10; k++) begin
            logic [3:0] eg;
            logic [1:0] ei;
            logic       eto;
`ifdef RR_ARBITER_TIMEOUT_EN
            if (k <= 4) begin
                eg = 4'b0001; ei = 2'd0; eto = 1'b0;
            end else if (k == 5 || k == 10) begin
                eg = 4'b0000; ei = 2'd0; eto = 1'b1;
            end else begin
                eg = 4'b0010; ei = 2'd1; eto = 1'b0;
            end
`else
            eg = 4'b0001; ei = 2'd0; eto = 1'b0;
`endif
            step(0, 4'b0011);
            check_all($sformatf("hold%0d", k), eg, ei, eto);
        end

        // Owner 0 held for MAX_HOLD cycles, then releases on the timeout edge
        for (int k = 11; k <= 14; k++) begin
            step(0, 4'b0011);
            check_all($sformatf("hold%0d", k), 4'b0001, 2'd0, 1'b0);
        end
        step(0, 4'b0000);
        check_all("rel_at_limit", 4'b0000, 2'd0, 1'b0);
        step(0, 4'b0000);
        check_all("idle_after", 4'b0000, 2'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
